// File: rtl/agu_pkg.sv
// rtl/agu_pkg.sv - shared types and constants for the AGU loop sequencer
package agu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_ISSUE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int BANK_A = 0;
   localparam int BANK_B = 1;
   localparam int BANK_C = 2;
   localparam int BANK_D = 3;

   localparam int AGU_ADDR_WIDTH = 12;

   // AGU start addresses carry two bits beyond the bank address
   function automatic int start_width(input int addr_width);
      return addr_width + 2;
   endfunction

endpackage

// File: rtl/agu_loop_ctr.sv
// rtl/agu_loop_ctr.sv - loop index counter with programmable last value
// Counts 0..i_limit, returning to 0 on the increment taken at i_limit.
module agu_loop_ctr
   import agu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_inc,
   input  logic [WIDTH-1:0] i_limit,
   output logic             o_wrap,
   output logic             o_zero
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc) begin
         r_count <= o_wrap ? '0 : r_count + WIDTH'(1);
      end
   end

   assign o_wrap = (r_count == i_limit);
   assign o_zero = (r_count == '0);

endmodule

// File: rtl/agu_loop_seq.sv
// rtl/agu_loop_seq.sv - row/column/inner loop sequencer driving the AGU banks
// A and B start registers double as the row/column address accumulators.
module agu_loop_seq
   import agu_pkg::*;
#(
   parameter int ADDR_WIDTH = AGU_ADDR_WIDTH,
   parameter int DIM_WIDTH  = 11,
   parameter int COL_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DIM_WIDTH-1:0]  cfg_rows,
   input  logic [COL_WIDTH-1:0]  cfg_cols,
   input  logic [DIM_WIDTH-1:0]  cfg_inner,
   input  logic [3:0]            cfg_stride,
   input  logic [ADDR_WIDTH+1:0] cfg_a_base,
   input  logic [ADDR_WIDTH+1:0] cfg_b_base,
   input  logic [ADDR_WIDTH+1:0] cfg_c_base,
   input  logic [ADDR_WIDTH+1:0] cfg_d_base,
   input  logic                  stall,
   output logic [ADDR_WIDTH+1:0] A_addr_start,
   output logic [ADDR_WIDTH+1:0] B_addr_start,
   output logic [ADDR_WIDTH+1:0] C_addr_start,
   output logic [ADDR_WIDTH+1:0] D_addr_start,
   output logic [3:0]            clr_en,
   output logic [3:0]            add_en,
   output logic [3:0]            stride,
   output logic                  mac_first,
   output logic                  mac_last,
   output logic                  busy,
   output logic                  done
);

   localparam int SW = start_width(ADDR_WIDTH);

   state_t r_state, w_next;

   logic [SW-1:0]        r_a_start, r_b_start, r_c_start, r_d_start, r_b_base;
   logic [3:0]           r_stride;
   logic [DIM_WIDTH-1:0] r_inner, r_k_last, r_r_last;
   logic [COL_WIDTH-1:0] r_c_last;

   logic w_go, w_zero_job, w_step, w_clr_ctr;
   logic w_k_wrap, w_k_zero, w_c_wrap, w_c_zero, w_r_wrap, w_r_zero;
   logic w_last_term;

   assign w_go        = (r_state == ST_IDLE) && start;
   assign w_zero_job  = (cfg_rows == '0) || (cfg_cols == '0) || (cfg_inner == '0);
   assign w_step      = (r_state == ST_ISSUE) && !stall;
   assign w_clr_ctr   = (r_state == ST_IDLE);
   assign w_last_term = w_step && w_k_wrap;

   agu_loop_ctr #(.WIDTH(DIM_WIDTH)) u_k_ctr (
      .clk(clk), .rst(rst), .i_clr(w_clr_ctr), .i_inc(w_step),
      .i_limit(r_k_last), .o_wrap(w_k_wrap), .o_zero(w_k_zero)
   );

   agu_loop_ctr #(.WIDTH(COL_WIDTH)) u_c_ctr (
      .clk(clk), .rst(rst), .i_clr(w_clr_ctr), .i_inc(w_last_term),
      .i_limit(r_c_last), .o_wrap(w_c_wrap), .o_zero(w_c_zero)
   );

   agu_loop_ctr #(.WIDTH(DIM_WIDTH)) u_r_ctr (
      .clk(clk), .rst(rst), .i_clr(w_clr_ctr), .i_inc(w_last_term && w_c_wrap),
      .i_limit(r_r_last), .o_wrap(w_r_wrap), .o_zero(w_r_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (start) w_next = w_zero_job ? ST_DONE : ST_LOAD;
         ST_LOAD:  w_next = ST_ISSUE;
         ST_ISSUE: if (w_last_term) w_next = (w_c_wrap && w_r_wrap) ? ST_DONE : ST_LOAD;
         ST_DONE:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // Job configuration and address walk; the final term leaves addresses as they are
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a_start <= '0;
         r_b_start <= '0;
         r_c_start <= '0;
         r_d_start <= '0;
         r_b_base  <= '0;
         r_stride  <= '0;
         r_inner   <= '0;
         r_k_last  <= '0;
         r_c_last  <= '0;
         r_r_last  <= '0;
      end else if (w_go) begin
         r_a_start <= cfg_a_base;
         r_b_start <= cfg_b_base;
         r_c_start <= cfg_c_base;
         r_d_start <= cfg_d_base;
         r_b_base  <= cfg_b_base;
         r_stride  <= cfg_stride;
         r_inner   <= cfg_inner;
         r_k_last  <= cfg_inner - DIM_WIDTH'(1);
         r_c_last  <= cfg_cols - COL_WIDTH'(1);
         r_r_last  <= cfg_rows - DIM_WIDTH'(1);
      end else if (w_last_term && !(w_c_wrap && w_r_wrap)) begin
         if (!w_c_wrap) begin
            r_b_start <= r_b_start + SW'(r_inner);
         end else begin
            r_b_start <= r_b_base;
            r_a_start <= r_a_start + SW'(r_inner);
         end
      end
   end

   // The first LOAD of a job is the only one seen with both row and column at zero
   always_comb begin
      clr_en    = '0;
      add_en    = '0;
      mac_first = 1'b0;
      mac_last  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (r_state)
         ST_LOAD: begin
            busy           = 1'b1;
            clr_en[BANK_A] = 1'b1;
            clr_en[BANK_B] = 1'b1;
            if (w_c_zero && w_r_zero) begin
               clr_en[BANK_C] = 1'b1;
               clr_en[BANK_D] = 1'b1;
            end
         end
         ST_ISSUE: begin
            busy = 1'b1;
            if (!stall) begin
               add_en[BANK_A] = 1'b1;
               add_en[BANK_B] = 1'b1;
               add_en[BANK_C] = w_k_wrap;
               add_en[BANK_D] = w_k_wrap;
               mac_first      = w_k_zero;
               mac_last       = w_k_wrap;
            end
         end
         ST_DONE:  done = 1'b1;
         default:  ;
      endcase
   end

   assign A_addr_start = r_a_start;
   assign B_addr_start = r_b_start;
   assign C_addr_start = r_c_start;
   assign D_addr_start = r_d_start;
   assign stride       = r_stride;

endmodule

// File: tb/tb_agu_loop_seq.sv
// tb/tb_agu_loop_seq.sv - scoreboard bench for agu_loop_seq
module tb_agu_loop_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [10:0] cfg_rows = '0;
   logic [3:0]  cfg_cols = '0;
   logic [10:0] cfg_inner = '0;
   logic [3:0]  cfg_stride = '0;
   logic [13:0] cfg_a_base = '0, cfg_b_base = '0, cfg_c_base = '0, cfg_d_base = '0;
   logic        stall = 1'b0;
   logic [13:0] A_addr_start, B_addr_start, C_addr_start, D_addr_start;
   logic [3:0]  clr_en, add_en, stride;
   logic        mac_first, mac_last, busy, done;

   agu_loop_seq dut (
      .clk(clk), .rst(rst), .start(start),
      .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_inner(cfg_inner),
      .cfg_stride(cfg_stride),
      .cfg_a_base(cfg_a_base), .cfg_b_base(cfg_b_base),
      .cfg_c_base(cfg_c_base), .cfg_d_base(cfg_d_base),
      .stall(stall),
      .A_addr_start(A_addr_start), .B_addr_start(B_addr_start),
      .C_addr_start(C_addr_start), .D_addr_start(D_addr_start),
      .clr_en(clr_en), .add_en(add_en), .stride(stride),
      .mac_first(mac_first), .mac_last(mac_last),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [66:0] data;
      logic [66:0] mask;
   } ev_t;

   ev_t         sb[$];
   int          cyc = 0;
   int          t0 = 0;
   int          checks = 0;
   int          failures = 0;
   logic [13:0] jc, jd;

   always @(posedge clk) cyc <= cyc + 1;

   // Expected event at cycle n of the current job: clr, add, A, B starts, markers, done
   task automatic ex(input int n, input logic [3:0] c_en, input logic [3:0] a_en,
                     input logic [13:0] a, input logic [13:0] b,
                     input logic mf, input logic ml, input logic dn, input logic addr_chk);
      ev_t e;
      e.cyc  = t0 + n;
      e.data = {c_en, a_en, a, b, jc, jd, mf, ml, dn};
      e.mask = addr_chk ? {67{1'b1}} : {8'hFF, 56'h0, 3'b111};
      sb.push_back(e);
   endtask

   task automatic launch(input logic [10:0] rows, input logic [3:0] cols, input logic [10:0] inner,
                         input logic [13:0] a, input logic [13:0] b,
                         input logic [13:0] c, input logic [13:0] d);
      cfg_rows = rows; cfg_cols = cols; cfg_inner = inner; cfg_stride = 4'h5;
      cfg_a_base = a; cfg_b_base = b; cfg_c_base = c; cfg_d_base = d;
      jc = c; jd = d;
      start = 1'b1;
      t0 = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_until(input int n);
      while (cyc < t0 + n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic job1_head();
      ex(1, 4'hF, 4'h0, 14'h010, 14'h020, 0, 0, 0, 1);
      ex(2, 4'h0, 4'h3, 14'h010, 14'h020, 1, 0, 0, 1);
   endtask

   task automatic check_sb_empty(input string name);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL %s pending=%0d required=0", name, sb.size());
         sb.delete();
      end
   endtask

   // Monitor: every cycle the DUT shows a strobe, marker or done is one scoreboard event
   always @(negedge clk) begin
      if (!rst && ((|clr_en) || (|add_en) || done || mac_first || mac_last)) begin
         logic [66:0] obs;
         ev_t e;
         obs = {clr_en, add_en, A_addr_start, B_addr_start, C_addr_start, D_addr_start,
                mac_first, mac_last, done};
         checks++;
         if ((clr_en & add_en) != 4'h0) begin
            failures++;
            $display("FAIL clr_add_overlap cyc=%0d clr=%b add=%b", cyc, clr_en, add_en);
         end
         if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_event cyc=%0d got=%h required=none", cyc, obs);
         end else begin
            e = sb.pop_front();
            checks++;
            if (cyc != e.cyc) begin
               failures++;
               $display("FAIL event_cycle got=%0d required=%0d", cyc, e.cyc);
            end
            checks++;
            if ((obs & e.mask) != (e.data & e.mask)) begin
               failures++;
               $display("FAIL event_data cyc=%0d got=%h required=%h", cyc, obs & e.mask, e.data & e.mask);
            end
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({clr_en, add_en, busy, done, mac_first, mac_last, stride, A_addr_start,
           B_addr_start, C_addr_start, D_addr_start} != '0) begin
         failures++;
         $display("FAIL reset_state got clr=%b add=%b busy=%b done=%b A=%h required all zero",
                  clr_en, add_en, busy, done, A_addr_start);
      end
      @(posedge clk); #1;

      // Single 1x1 job, K=3
      launch(11'd1, 4'd1, 11'd3, 14'h010, 14'h020, 14'h030, 14'h040);
      job1_head();
      ex(3, 4'h0, 4'h3, 14'h010, 14'h020, 0, 0, 0, 1);
      ex(4, 4'h0, 4'hF, 14'h010, 14'h020, 0, 1, 0, 1);
      ex(5, 4'h0, 4'h0, 14'h010, 14'h020, 0, 0, 1, 1);
      checks++;
      if (stride != 4'h5) begin
         failures++;
         $display("FAIL stride_latch got=%h required=5", stride);
      end
      wait_until(8);
      check_sb_empty("job1_drain");

      // 2x2 job, K=2: row and column address walk
      launch(11'd2, 4'd2, 11'd2, 14'h100, 14'h200, 14'h300, 14'h400);
      ex(1,  4'hF, 4'h0, 14'h100, 14'h200, 0, 0, 0, 1);
      ex(2,  4'h0, 4'h3, 14'h100, 14'h200, 1, 0, 0, 1);
      ex(3,  4'h0, 4'hF, 14'h100, 14'h200, 0, 1, 0, 1);
      ex(4,  4'h3, 4'h0, 14'h100, 14'h202, 0, 0, 0, 1);
      ex(5,  4'h0, 4'h3, 14'h100, 14'h202, 1, 0, 0, 1);
      ex(6,  4'h0, 4'hF, 14'h100, 14'h202, 0, 1, 0, 1);
      ex(7,  4'h3, 4'h0, 14'h102, 14'h200, 0, 0, 0, 1);
      ex(8,  4'h0, 4'h3, 14'h102, 14'h200, 1, 0, 0, 1);
      ex(9,  4'h0, 4'hF, 14'h102, 14'h200, 0, 1, 0, 1);
      ex(10, 4'h3, 4'h0, 14'h102, 14'h202, 0, 0, 0, 1);
      ex(11, 4'h0, 4'h3, 14'h102, 14'h202, 1, 0, 0, 1);
      ex(12, 4'h0, 4'hF, 14'h102, 14'h202, 0, 1, 0, 1);
      ex(13, 4'h0, 4'h0, 14'h102, 14'h202, 0, 0, 1, 1);
      wait_until(16);
      check_sb_empty("job2_drain");

      // Job 1 with stall in cycles 3-4
      launch(11'd1, 4'd1, 11'd3, 14'h010, 14'h020, 14'h030, 14'h040);
      job1_head();
      ex(5, 4'h0, 4'h3, 14'h010, 14'h020, 0, 0, 0, 1);
      ex(6, 4'h0, 4'hF, 14'h010, 14'h020, 0, 1, 0, 1);
      ex(7, 4'h0, 4'h0, 14'h010, 14'h020, 0, 0, 1, 1);
      wait_until(3);
      stall = 1'b1;
      wait_until(5);
      stall = 1'b0;
      wait_until(10);
      check_sb_empty("stall_drain");

      // Zero inner dimension: done only, busy never raised
      launch(11'd1, 4'd1, 11'd0, 14'h050, 14'h060, 14'h070, 14'h080);
      ex(1, 4'h0, 4'h0, 14'h050, 14'h060, 0, 0, 1, 0);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL zero_job_busy got=%b required=0", busy);
      end
      wait_until(5);
      check_sb_empty("zero_job_drain");

      // Start pulses mid-job and in the DONE cycle are ignored
      launch(11'd1, 4'd1, 11'd3, 14'h010, 14'h020, 14'h030, 14'h040);
      job1_head();
      ex(3, 4'h0, 4'h3, 14'h010, 14'h020, 0, 0, 0, 1);
      ex(4, 4'h0, 4'hF, 14'h010, 14'h020, 0, 1, 0, 1);
      ex(5, 4'h0, 4'h0, 14'h010, 14'h020, 0, 0, 1, 1);
      wait_until(3);
      cfg_rows = 11'd3; cfg_cols = 4'd2; cfg_inner = 11'd5; cfg_stride = 4'hA;
      cfg_a_base = 14'h3FF0; cfg_b_base = 14'h1111;
      start = 1'b1;
      wait_until(4);
      start = 1'b0;
      wait_until(5);
      start = 1'b1;
      wait_until(6);
      start = 1'b0;
      wait_until(10);
      check_sb_empty("ignore_start_drain");
      checks++;
      if (stride != 4'h5) begin
         failures++;
         $display("FAIL ignored_cfg_stride got=%h required=5", stride);
      end

      // Reset in cycle 3 aborts with no done; a following job runs clean
      launch(11'd1, 4'd1, 11'd3, 14'h010, 14'h020, 14'h030, 14'h040);
      job1_head();
      wait_until(3);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({clr_en, add_en, busy, done, mac_first, mac_last, stride, A_addr_start,
           B_addr_start, C_addr_start, D_addr_start} != '0) begin
         failures++;
         $display("FAIL abort_outputs got clr=%b add=%b busy=%b done=%b A=%h required all zero",
                  clr_en, add_en, busy, done, A_addr_start);
      end
      check_sb_empty("abort_consumed");
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      launch(11'd1, 4'd2, 11'd1, 14'h0F0, 14'h3FFF, 14'h012, 14'h034);
      ex(1, 4'hF, 4'h0, 14'h0F0, 14'h3FFF, 0, 0, 0, 1);
      ex(2, 4'h0, 4'hF, 14'h0F0, 14'h3FFF, 1, 1, 0, 1);
      ex(3, 4'h3, 4'h0, 14'h0F0, 14'h0000, 0, 0, 0, 1);
      ex(4, 4'h0, 4'hF, 14'h0F0, 14'h0000, 1, 1, 0, 1);
      ex(5, 4'h0, 4'h0, 14'h0F0, 14'h0000, 0, 0, 1, 1);
      wait_until(8);
      check_sb_empty("post_reset_drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
